// File: rtl/calendar_pkg.sv
// Shared calendar definitions: field widths, month lengths and the
// leap-year / month-length helpers used by both the cascade and load checks.
package calendar_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MON_W-1:0]  MON_MIN  = 4'd1;
  localparam logic [MON_W-1:0]  MON_MAX  = 4'd12;
  localparam logic [DAY_W-1:0]  DAY_MIN  = 5'd1;

  localparam logic [DAY_W-1:0] DAYS_LONG     = 5'd31;
  localparam logic [DAY_W-1:0] DAYS_SHORT    = 5'd30;
  localparam logic [DAY_W-1:0] DAYS_FEB      = 5'd28;
  localparam logic [DAY_W-1:0] DAYS_FEB_LEAP = 5'd29;

  typedef enum logic [MON_W-1:0] {
    JAN = 4'd1, FEB = 4'd2, MAR = 4'd3, APR = 4'd4,
    MAY = 4'd5, JUN = 4'd6, JUL = 4'd7, AUG = 4'd8,
    SEP = 4'd9, OCT = 4'd10, NOV = 4'd11, DEC = 4'd12
  } month_e;

  // Gregorian rule; callers zero-extend their year to 32 bits.
  function automatic logic is_leap(input logic [31:0] year);
    return ((year % 32'd4) == 32'd0) &&
           (((year % 32'd100) != 32'd0) || ((year % 32'd400) == 32'd0));
  endfunction

  // Months outside 1..12 report 31; range checks reject them separately.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [31:0]      year,
                                                     input logic [MON_W-1:0] month);
    logic [DAY_W-1:0] days;
    case (month_e'(month))
      APR, JUN, SEP, NOV: days = DAYS_SHORT;
      FEB:                days = is_leap(year) ? DAYS_FEB_LEAP : DAYS_FEB;
      default:            days = DAYS_LONG;
    endcase
    return days;
  endfunction

endpackage

// File: rtl/calendar_rtc_sec_tick_gen.sv
// Seconds prescaler: counts clk cycles while run is high and flags the last
// cycle of each second. A valid date load restarts the second from zero.
module sec_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/calendar_rtc.sv
// Real-time calendar clock: second..year cascade with Gregorian month lengths,
// run/pause control and a validated whole-date load port. All outputs are flops.
module calendar_rtc
  import calendar_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned YEAR_W     = 12,
  parameter int unsigned RESET_YEAR = 2021,
  parameter int unsigned YEAR_MAX   = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              set_en,
  input  logic [YEAR_W-1:0] set_year,
  input  logic [MON_W-1:0]  set_month,
  input  logic [DAY_W-1:0]  set_day,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  output logic [YEAR_W-1:0] year,
  output logic [MON_W-1:0]  month,
  output logic [DAY_W-1:0]  day,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [SEC_W-1:0]  second,
  output logic              sec_tick,
  output logic              set_err
);

  localparam logic [YEAR_W-1:0] YEAR_LAST  = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] YEAR_RESET = YEAR_W'(RESET_YEAR);

  logic [YEAR_W-1:0] year_q, year_d;
  logic [MON_W-1:0]  month_q, month_d;
  logic [DAY_W-1:0]  day_q, day_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic              sec_tick_q, sec_tick_d;
  logic              set_err_q, set_err_d;

  logic             tick;
  logic             set_valid;
  logic             load;
  logic [DAY_W-1:0] dim_cur;
  logic [DAY_W-1:0] dim_set;

  assign dim_cur = days_in_month(32'(year_q), month_q);
  assign dim_set = days_in_month(32'(set_year), set_month);

  assign set_valid = (32'(set_year) <= YEAR_MAX) &&
                     (set_month >= MON_MIN) && (set_month <= MON_MAX) &&
                     (set_day >= DAY_MIN) && (set_day <= dim_set) &&
                     (set_hour <= HOUR_MAX) &&
                     (set_min <= MIN_MAX) &&
                     (set_sec <= SEC_MAX);

  assign load = set_en && set_valid;

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (load),
    .tick (tick)
  );

  // NOTE: every variable gets its hold value first so no path through the
  // conditionals leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    year_d     = year_q;
    month_d    = month_q;
    day_d      = day_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    set_err_d  = set_en && !set_valid;

    if (load) begin
      // A valid load wins over a coincident tick; that tick is dropped.
      year_d  = set_year;
      month_d = set_month;
      day_d   = set_day;
      hour_d  = set_hour;
      min_d   = set_min;
      sec_d   = set_sec;
    end else if (tick) begin
      sec_tick_d = 1'b1;
      if (sec_q != SEC_MAX) begin
        sec_d = sec_q + SEC_W'(1);
      end else begin
        sec_d = '0;
        if (min_q != MIN_MAX) begin
          min_d = min_q + MIN_W'(1);
        end else begin
          min_d = '0;
          if (hour_q != HOUR_MAX) begin
            hour_d = hour_q + HOUR_W'(1);
          end else begin
            hour_d = '0;
            if (day_q < dim_cur) begin
              day_d = day_q + DAY_W'(1);
            end else begin
              day_d = DAY_MIN;
              if (month_q < MON_MAX) begin
                month_d = month_q + MON_W'(1);
              end else begin
                month_d = MON_MIN;
                year_d  = (year_q == YEAR_LAST) ? '0 : year_q + YEAR_W'(1);
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      year_q     <= YEAR_RESET;
      month_q    <= MON_MIN;
      day_q      <= DAY_MIN;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      sec_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      year_q     <= year_d;
      month_q    <= month_d;
      day_q      <= day_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      set_err_q  <= set_err_d;
    end
  end

  assign year     = year_q;
  assign month    = month_q;
  assign day      = day_q;
  assign hour     = hour_q;
  assign minute   = min_q;
  assign second   = sec_q;
  assign sec_tick = sec_tick_q;
  assign set_err  = set_err_q;

endmodule

// File: tb/tb_calendar_rtc.sv
// Directed bench for calendar_rtc with TICK_DIV=4: reset, calendar carries,
// load rejection, pause/resume, load/tick priority and mid-count reset.
module tb_calendar_rtc;

  localparam int TICK_DIV = 4;

  typedef logic [37:0] stamp_t;  // {year[12], month[4], day[5], hour[5], min[6], sec[6]}
  typedef struct {
    stamp_t ld;
    stamp_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        set_en = 1'b0;
  logic [11:0] set_year = '0;
  logic [3:0]  set_month = '0;
  logic [4:0]  set_day = '0;
  logic [4:0]  set_hour = '0;
  logic [5:0]  set_min = '0;
  logic [5:0]  set_sec = '0;
  logic [11:0] year;
  logic [3:0]  month;
  logic [4:0]  day;
  logic [4:0]  hour;
  logic [5:0]  minute;
  logic [5:0]  second;
  logic        sec_tick;
  logic        set_err;

  int vectors = 0;
  int miscompares = 0;

  calendar_rtc #(
    .TICK_DIV   (TICK_DIV),
    .YEAR_W     (12),
    .RESET_YEAR (2021),
    .YEAR_MAX   (4095)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .set_en    (set_en),
    .set_year  (set_year),
    .set_month (set_month),
    .set_day   (set_day),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .year      (year),
    .month     (month),
    .day       (day),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .sec_tick  (sec_tick),
    .set_err   (set_err)
  );

  always #5 clk = ~clk;

  function automatic stamp_t mk(int y, int mo, int d, int h, int mi, int s);
    return {12'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
  endfunction

  function automatic stamp_t now();
    return {year, month, day, hour, minute, second};
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_set(stamp_t v);
    {set_year, set_month, set_day, set_hour, set_min, set_sec} = v;
    set_en = 1'b1;
    step(1);
    set_en = 1'b0;
  endtask

  // Edges until sec_tick is seen, or -1 if it never arrives within the budget.
  task automatic wait_tick(output int n);
    bit seen;
    n = -1;
    seen = 1'b0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      step(1);
      if (sec_tick === 1'b1) begin
        n = i;
        seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    stamp_t exp;
    rst = 1'b1;
    run = 1'b0;
    step(2);
    exp = mk(2021, 1, 1, 0, 0, 0);
    vectors++;
    if (now() !== exp || sec_tick !== 1'b0 || set_err !== 1'b0) begin
      $display("FAIL reset_state: got %h tick=%b err=%b exp %h tick=0 err=0",
               now(), sec_tick, set_err, exp);
      miscompares++;
    end
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      vectors++;
      if (sec_tick !== ((i % 4) == 3)) begin
        $display("FAIL tick_cadence[%0d]: got %b exp %b", i, sec_tick, (i % 4) == 3);
        miscompares++;
      end
    end
    exp = mk(2021, 1, 1, 0, 0, 3);
    vectors++;
    if (now() !== exp) begin
      $display("FAIL three_ticks: got %h exp %h", now(), exp);
      miscompares++;
    end
  endtask

  task automatic test_carry();
    vec_t vecs[9];
    int   n;
    vecs[0] = '{mk(2024, 2, 28, 23, 59, 59), mk(2024, 2, 29, 0, 0, 0)};
    vecs[1] = '{mk(2023, 2, 28, 23, 59, 59), mk(2023, 3, 1, 0, 0, 0)};
    vecs[2] = '{mk(1900, 2, 28, 23, 59, 59), mk(1900, 3, 1, 0, 0, 0)};
    vecs[3] = '{mk(2000, 2, 28, 23, 59, 59), mk(2000, 2, 29, 0, 0, 0)};
    vecs[4] = '{mk(2024, 2, 29, 23, 59, 59), mk(2024, 3, 1, 0, 0, 0)};
    vecs[5] = '{mk(2021, 4, 30, 23, 59, 59), mk(2021, 5, 1, 0, 0, 0)};
    vecs[6] = '{mk(2021, 6, 15, 10, 59, 59), mk(2021, 6, 15, 11, 0, 0)};
    vecs[7] = '{mk(2021, 12, 31, 23, 59, 59), mk(2022, 1, 1, 0, 0, 0)};
    vecs[8] = '{mk(4095, 12, 31, 23, 59, 59), mk(0, 1, 1, 0, 0, 0)};
    foreach (vecs[i]) begin
      apply_set(vecs[i].ld);
      vectors++;
      if (now() !== vecs[i].ld || sec_tick !== 1'b0 || set_err !== 1'b0) begin
        $display("FAIL carry_load[%0d]: got %h tick=%b err=%b exp %h tick=0 err=0",
                 i, now(), sec_tick, set_err, vecs[i].ld);
        miscompares++;
      end
      wait_tick(n);
      vectors++;
      if (n != TICK_DIV) begin
        $display("FAIL carry_latency[%0d]: got %0d exp %0d", i, n, TICK_DIV);
        miscompares++;
      end
      vectors++;
      if (now() !== vecs[i].exp) begin
        $display("FAIL carry_result[%0d]: got %h exp %h", i, now(), vecs[i].exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_reject();
    stamp_t bad[6];
    stamp_t cur;
    int     n;
    bad[0] = mk(2023, 2, 29, 12, 0, 0);
    bad[1] = mk(2021, 1, 1, 24, 0, 0);
    bad[2] = mk(2021, 4, 31, 0, 0, 0);
    bad[3] = mk(2021, 13, 1, 0, 0, 0);
    bad[4] = mk(2021, 1, 1, 0, 60, 0);
    bad[5] = mk(2021, 1, 0, 0, 0, 0);
    cur = mk(0, 1, 1, 0, 0, 0);
    foreach (bad[i]) begin
      apply_set(bad[i]);
      vectors++;
      if (set_err !== 1'b1 || now() !== cur || sec_tick !== 1'b0) begin
        $display("FAIL reject[%0d]: got err=%b %h tick=%b exp err=1 %h tick=0",
                 i, set_err, now(), sec_tick, cur);
        miscompares++;
      end
      step(1);
      vectors++;
      if (set_err !== 1'b0) begin
        $display("FAIL reject_pulse[%0d]: got %b exp 0", i, set_err);
        miscompares++;
      end
      wait_tick(n);
      cur = mk(0, 1, 1, 0, 0, i + 1);
      vectors++;
      if (n != 2 || now() !== cur) begin
        $display("FAIL reject_schedule[%0d]: got n=%0d %h exp n=2 %h", i, n, now(), cur);
        miscompares++;
      end
    end
    step(3);
    apply_set(bad[0]);
    cur = mk(0, 1, 1, 0, 0, 7);
    vectors++;
    if (set_err !== 1'b1 || sec_tick !== 1'b1 || now() !== cur) begin
      $display("FAIL reject_with_tick: got err=%b tick=%b %h exp err=1 tick=1 %h",
               set_err, sec_tick, now(), cur);
      miscompares++;
    end
  endtask

  task automatic test_pause();
    stamp_t cur;
    int     n;
    cur = mk(0, 1, 1, 0, 0, 7);
    step(1);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      vectors++;
      if (sec_tick !== 1'b0 || now() !== cur) begin
        $display("FAIL pause[%0d]: got tick=%b %h exp tick=0 %h", i, sec_tick, now(), cur);
        miscompares++;
      end
    end
    run = 1'b1;
    wait_tick(n);
    cur = mk(0, 1, 1, 0, 0, 8);
    vectors++;
    if (n != 3 || now() !== cur) begin
      $display("FAIL resume: got n=%0d %h exp n=3 %h", n, now(), cur);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    stamp_t a, b, exp;
    int     n;
    a = mk(2030, 6, 15, 8, 30, 0);
    b = mk(2031, 1, 31, 23, 59, 59);
    step(3);
    apply_set(a);
    vectors++;
    if (sec_tick !== 1'b0 || now() !== a) begin
      $display("FAIL set_over_tick: got tick=%b %h exp tick=0 %h", sec_tick, now(), a);
      miscompares++;
    end
    wait_tick(n);
    exp = mk(2030, 6, 15, 8, 30, 1);
    vectors++;
    if (n != TICK_DIV || now() !== exp) begin
      $display("FAIL set_over_tick_next: got n=%0d %h exp n=%0d %h", n, now(), TICK_DIV, exp);
      miscompares++;
    end
    apply_set(a);
    apply_set(b);
    vectors++;
    if (now() !== b) begin
      $display("FAIL back_to_back_load: got %h exp %h", now(), b);
      miscompares++;
    end
    wait_tick(n);
    exp = mk(2031, 2, 1, 0, 0, 0);
    vectors++;
    if (n != TICK_DIV || now() !== exp) begin
      $display("FAIL back_to_back_tick: got n=%0d %h exp n=%0d %h", n, now(), TICK_DIV, exp);
      miscompares++;
    end
  endtask

  task automatic test_frozen_load();
    stamp_t v, exp;
    int     n;
    v = mk(2022, 7, 4, 12, 0, 0);
    run = 1'b0;
    apply_set(v);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (sec_tick !== 1'b0 || now() !== v) begin
        $display("FAIL frozen_load[%0d]: got tick=%b %h exp tick=0 %h", i, sec_tick, now(), v);
        miscompares++;
      end
      step(1);
    end
    run = 1'b1;
    wait_tick(n);
    exp = mk(2022, 7, 4, 12, 0, 1);
    vectors++;
    if (n != TICK_DIV || now() !== exp) begin
      $display("FAIL frozen_resume: got n=%0d %h exp n=%0d %h", n, now(), TICK_DIV, exp);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    stamp_t exp;
    int     n;
    step(2);
    {set_year, set_month, set_day, set_hour, set_min, set_sec} = mk(2040, 5, 5, 5, 5, 5);
    set_en = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    set_en = 1'b0;
    exp = mk(2021, 1, 1, 0, 0, 0);
    vectors++;
    if (now() !== exp || sec_tick !== 1'b0 || set_err !== 1'b0) begin
      $display("FAIL reset_mid: got %h tick=%b err=%b exp %h tick=0 err=0",
               now(), sec_tick, set_err, exp);
      miscompares++;
    end
    wait_tick(n);
    exp = mk(2021, 1, 1, 0, 0, 1);
    vectors++;
    if (n != TICK_DIV || now() !== exp) begin
      $display("FAIL reset_mid_tick: got n=%0d %h exp n=%0d %h", n, now(), TICK_DIV, exp);
      miscompares++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_carry();
    test_reject();
    test_pause();
    test_back_to_back();
    test_frozen_load();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
